sccb_byte_master: RTL and testbench
===================================

// Module: sccb_byte_master
// PURPOSE
//  Open-drain SCCB/I2C write-only byte engine sitting directly under the SCCB control unit.
//  - Turns the control unit's en/start/stop/tx_data requests into START, 8 data bits,
//    9th (ACK) bit and STOP on SCL/SDA.
//  - Reports per-byte completion (tx_done) and slave NACK (ack_error) back up.
//  - Drives the OV7670 configuration bus at 100 kHz from the 100 MHz system clock.
// PARAMETERS
//  SYS_CLOCK_FREQ     100_000_000  system clock frequency, Hz
//  TARGET_CLOCK_FREQ  100_000      SCL frequency, Hz
//  DIV_SCALE          4            quarter-phases per SCL bit (fixed 4; other values unsupported)
//  CHECK_ACK          1            1: SDA high on 9th bit is a NACK; 0: 9th bit ignored (pure SCCB)
// PORTS
//  clk        in     1  system clock
//  reset      in     1  asynchronous, active-low reset
//  I2C_en     in     1  enable; sampled only in IDLE
//  I2C_start  in     1  1-cycle request: begin a transaction, first byte = tx_data
//  I2C_stop   in     1  level: the byte in flight is the last one; STOP follows its 9th bit
//  tx_data    in     8  byte to send; captured on an accepted start and on each non-final tx_done
//  tx_done    out    1  1-cycle pulse: byte finished (or, for the last byte, STOP finished)
//  tx_ready   out    1  high in IDLE only (new start accepted)
//  ack_error  out    1  1-cycle pulse after NACK-forced STOP completes
//  SCL        out    1  tri; drives 0 or 'z' (external pull-up)
//  SDA        inout  1  tri; drives 0 or 'z'; read during 9th bit
// BEHAVIOUR
//  - Divider: QTR = SYS_CLOCK_FREQ/(TARGET_CLOCK_FREQ*DIV_SCALE) = 250 cycles.
//    - qtick pulses every QTR cycles while not IDLE.
//    - Counter cleared in IDLE, so the first qtick comes QTR cycles after start is accepted.
//  - Reset (or in IDLE):
//    - SCL = z, SDA = z.
//    - tx_done = 0, ack_error = 0, tx_ready = 1.
//    - Shift register, bit count and quarter count = 0.
//  - States and transitions (q0..q3 = quarter index, advanced on qtick):
//    - IDLE:  if I2C_en && I2C_start -> latch tx_data, go to START. I2C_start without I2C_en is ignored.
//    - START: q0 SCL=z SDA=z; q1 SDA=0; q2,q3 SCL=0 -> DATA, bit 7.
//    - DATA:  MSB first.
//      - q0: SCL=0, SDA=bit (1 -> z).
//      - q1, q2: SCL=z.
//      - q3: SCL=0.
//      - After bit 0 -> ACK.
//    - ACK:   SDA released (z); SCL per DATA pattern; SDA sampled on the q2 qtick.
//      - On the q3 qtick:
//        - NACK && CHECK_ACK -> STOP, nack flag set.
//        - Else if I2C_stop -> STOP.
//        - Else pulse tx_done, latch tx_data in that same cycle -> DATA, bit 7.
//    - STOP:  q0 SCL=0 SDA=0; q1 SCL=z; q2 SDA=z; q3 bus idle.
//      - On the q3 qtick -> IDLE, pulsing ack_error if the nack flag is set, otherwise tx_done.
//  - Stop handling:
//    - I2C_stop is sampled only at the ACK q3 qtick.
//    - A request that arrives too late applies to the next byte.
//  - Ignored inputs:
//    - I2C_start is ignored outside IDLE (no queueing).
//    - I2C_en falling mid-transaction is ignored; the transaction runs to STOP.
//  - Timing per transaction:
//    - 3-byte write = START(4q) + 3x36q + STOP(4q) = 116q = 29000 cycles.
//    - Last tx_done is at that cycle; tx_ready is high the next cycle.
//  - Reset mid-operation: all state cleared immediately; SCL/SDA released to z (bus may see a spurious STOP).
//  - tx_done and ack_error are never high in the same cycle.
// STRUCTURE
//  - sccb_pkg:
//    - typedef enum {IDLE, START, DATA, ACK, STOP} sccb_state_e
//    - localparam function qtr_count(sys, scl, scale)
//  - Sub-module sccb_qtick_gen (parameter QTR): counter with synchronous clear; outputs the 1-cycle qtick.
//  - Top: FSM + 2-bit quarter counter + 3-bit bit counter + 8-bit shift register + open-drain output regs.
// TESTING
//  1. en=1, start with 0x42; stop asserted for the 3rd byte; data 0x12, 0x80; slave model ACKs.
//     -> SDA bits 0100_0010, 0001_0010, 1000_0000 MSB first.
//     -> tx_done at +9000 and +18000 cycles after START entry, final tx_done after STOP.
//     -> SCL period 1000 cycles.
//  2. Slave NACKs the 2nd byte.
//     -> no tx_done for byte 2; STOP generated; single ack_error pulse; tx_ready returns high.
//  3. CHECK_ACK=0, slave NACKs every byte.
//     -> 3 tx_done pulses, no ack_error.
//  4. Start pulse mid-byte and with I2C_en=0 in IDLE.
//     -> both ignored; SCL/SDA unchanged.
//  5. Reset asserted at bit 4 of byte 1.
//     -> SCL=z, SDA=z and all outputs 0 within the same cycle; a fresh start works afterwards.
//  6. Back-to-back: start in the cycle after the final tx_done.
//     -> accepted; START begins with no dropped request.

Source files
------------

// File: rtl/sccb_pkg.sv
// Shared types and divider arithmetic for the SCCB byte master.
package sccb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        ACK,
        STOP
    } sccb_state_e;

    // System clocks per quarter of an SCL bit.
    function automatic int qtr_count(input int sys_hz, input int scl_hz, input int scale);
        return sys_hz / (scl_hz * scale);
    endfunction

endpackage

// File: rtl/sccb_qtick_gen.sv
// Quarter-phase tick generator: one-cycle pulse every QTR clocks, held at zero while cleared.
module sccb_qtick_gen #(
    parameter int QTR = 250
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    output logic o_qtick
);
    localparam int CW = (QTR > 1) ? $clog2(QTR) : 1;
    localparam logic [CW-1:0] LAST = CW'(QTR - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clr || r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_qtick = !i_clr && (r_cnt == LAST);

endmodule

// File: rtl/sccb_byte_master.sv
// SCCB/I2C write-only byte engine: START, MSB-first bytes each followed by an ACK slot, STOP.
// SCL/SDA are open-drain; every bus bit spans four quarter-phases of the qtick.
module sccb_byte_master
    import sccb_pkg::*;
#(
    parameter int SYS_CLOCK_FREQ    = 100_000_000,
    parameter int TARGET_CLOCK_FREQ = 100_000,
    parameter int DIV_SCALE         = 4,
    parameter bit CHECK_ACK         = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       I2C_en,
    input  logic       I2C_start,
    input  logic       I2C_stop,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic       tx_ready,
    output logic       ack_error,
    output wire        SCL,
    inout  wire        SDA
);
    localparam int QTR = qtr_count(SYS_CLOCK_FREQ, TARGET_CLOCK_FREQ, DIV_SCALE);

    sccb_state_e r_state, w_state_nxt;
    logic [1:0]  r_q, w_q_nxt;
    logic [2:0]  r_bit, w_bit_nxt;
    logic [7:0]  r_shreg, w_shreg_nxt;
    logic        r_nack, w_nack_nxt;
    logic        r_nack_flag, w_nack_flag_nxt;
    logic        r_scl_lo, r_sda_lo;
    logic        w_qtick, w_clr, w_sda_in;
    logic [1:0]  w_drive;

    assign w_clr    = (r_state == IDLE);
    assign w_sda_in = SDA;

    sccb_qtick_gen #(.QTR(QTR)) u_qtick (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_clr),
        .o_qtick (w_qtick)
    );

    // Bus pattern {scl_lo, sda_lo} for a given state, quarter and current data bit.
    function automatic logic [1:0] bus_drive(input sccb_state_e st, input logic [1:0] q,
                                             input logic b);
        logic [1:0] drv;
        drv = 2'b00;
        case (st)
            START: drv = (q == 2'd0) ? 2'b00 : (q == 2'd1) ? 2'b01 : 2'b11;
            DATA:  drv = {(q == 2'd0 || q == 2'd3), !b};
            ACK:   drv = {(q == 2'd0 || q == 2'd3), 1'b0};
            STOP:  drv = (q == 2'd0) ? 2'b11 : (q == 2'd1) ? 2'b01 : 2'b00;
            default: drv = 2'b00;
        endcase
        return drv;
    endfunction

    always_comb begin
        w_state_nxt     = r_state;
        w_q_nxt         = r_q;
        w_bit_nxt       = r_bit;
        w_shreg_nxt     = r_shreg;
        w_nack_nxt      = r_nack;
        w_nack_flag_nxt = r_nack_flag;
        tx_done         = 1'b0;
        ack_error       = 1'b0;
        case (r_state)
            IDLE: begin
                w_q_nxt         = 2'd0;
                w_bit_nxt       = 3'd0;
                w_shreg_nxt     = 8'd0;
                w_nack_nxt      = 1'b0;
                w_nack_flag_nxt = 1'b0;
                if (I2C_en && I2C_start) begin
                    w_state_nxt = START;
                    w_shreg_nxt = tx_data;
                end
            end
            default: begin
                if (w_qtick) begin
                    w_q_nxt = r_q + 2'd1;
                    case (r_state)
                        START: begin
                            if (r_q == 2'd3) begin
                                w_state_nxt = DATA;
                                w_bit_nxt   = 3'd7;
                            end
                        end
                        DATA: begin
                            if (r_q == 2'd3) begin
                                if (r_bit == 3'd0) begin
                                    w_state_nxt = ACK;
                                end else begin
                                    w_bit_nxt   = r_bit - 3'd1;
                                    w_shreg_nxt = {r_shreg[6:0], 1'b0};
                                end
                            end
                        end
                        ACK: begin
                            // Sample mid-high of the 9th SCL pulse; a released (high) SDA is a NACK.
                            if (r_q == 2'd2) begin
                                w_nack_nxt = w_sda_in;
                            end
                            if (r_q == 2'd3) begin
                                if (r_nack && CHECK_ACK) begin
                                    w_state_nxt     = STOP;
                                    w_nack_flag_nxt = 1'b1;
                                end else if (I2C_stop) begin
                                    w_state_nxt = STOP;
                                end else begin
                                    tx_done     = 1'b1;
                                    w_shreg_nxt = tx_data;
                                    w_bit_nxt   = 3'd7;
                                    w_state_nxt = DATA;
                                end
                            end
                        end
                        STOP: begin
                            if (r_q == 2'd3) begin
                                w_state_nxt = IDLE;
                                if (r_nack_flag) begin
                                    ack_error = 1'b1;
                                end else begin
                                    tx_done = 1'b1;
                                end
                            end
                        end
                        default: begin
                            w_state_nxt = IDLE;
                        end
                    endcase
                end
            end
        endcase
    end

    assign w_drive = bus_drive(w_state_nxt, w_q_nxt, w_shreg_nxt[7]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_q         <= 2'd0;
            r_bit       <= 3'd0;
            r_shreg     <= 8'd0;
            r_nack      <= 1'b0;
            r_nack_flag <= 1'b0;
            r_scl_lo    <= 1'b0;
            r_sda_lo    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_q         <= w_q_nxt;
            r_bit       <= w_bit_nxt;
            r_shreg     <= w_shreg_nxt;
            r_nack      <= w_nack_nxt;
            r_nack_flag <= w_nack_flag_nxt;
            r_scl_lo    <= w_drive[1];
            r_sda_lo    <= w_drive[0];
        end
    end

    assign tx_ready = (r_state == IDLE);
    assign SCL      = r_scl_lo ? 1'b0 : 1'bz;
    assign SDA      = r_sda_lo ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_sccb_byte_master.sv
// Directed bench: three masters share one pulled-up bus with a byte-level slave model.
`timescale 1ns/1ps
module tb_sccb_byte_master;
    localparam int QA = 250;  // 100 MHz / (100 kHz * 4)
    localparam int QB = 25;   // 10 MHz / (100 kHz * 4)

    logic       clk = 1'b0;
    logic       reset, en, start_req, stop;
    logic [7:0] tx_data;
    logic [1:0] sel;
    logic       slv_lo;
    logic [2:0] done_v, rdy_v, err_v;
    logic       tx_done_m, tx_ready_m, ack_error_m;
    wire        scl_bus, sda_bus;

    pullup (scl_bus);
    pullup (sda_bus);
    assign sda_bus = slv_lo ? 1'b0 : 1'bz;

    sccb_byte_master u_a (
        .clk(clk), .reset(reset), .I2C_en(en), .I2C_start(start_req && sel == 2'd0),
        .I2C_stop(stop), .tx_data(tx_data), .tx_done(done_v[0]), .tx_ready(rdy_v[0]),
        .ack_error(err_v[0]), .SCL(scl_bus), .SDA(sda_bus));
    sccb_byte_master #(.SYS_CLOCK_FREQ(10_000_000)) u_b (
        .clk(clk), .reset(reset), .I2C_en(en), .I2C_start(start_req && sel == 2'd1),
        .I2C_stop(stop), .tx_data(tx_data), .tx_done(done_v[1]), .tx_ready(rdy_v[1]),
        .ack_error(err_v[1]), .SCL(scl_bus), .SDA(sda_bus));
    sccb_byte_master #(.SYS_CLOCK_FREQ(10_000_000), .CHECK_ACK(1'b0)) u_c (
        .clk(clk), .reset(reset), .I2C_en(en), .I2C_start(start_req && sel == 2'd2),
        .I2C_stop(stop), .tx_data(tx_data), .tx_done(done_v[2]), .tx_ready(rdy_v[2]),
        .ack_error(err_v[2]), .SCL(scl_bus), .SDA(sda_bus));

    assign tx_done_m   = (sel == 2'd0) ? done_v[0] : (sel == 2'd1) ? done_v[1] : done_v[2];
    assign tx_ready_m  = (sel == 2'd0) ? rdy_v[0]  : (sel == 2'd1) ? rdy_v[1]  : rdy_v[2];
    assign ack_error_m = (sel == 2'd0) ? err_v[0]  : (sel == 2'd1) ? err_v[1]  : err_v[2];

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor and slave model
    int         n_chk = 0, n_fail = 0;
    int         acc_t, n_done, n_err, err_t, n_start, n_stop, nbits, nbyte;
    int         last_rise, per_min, per_max, p;
    int         done_t [8];
    int         done_abs [8];
    logic [7:0] rx [8];
    logic [7:0] cur, nack_mask;
    logic       prev_scl, prev_sda, prev_rdy, both;

    always @(negedge clk) begin
        if (prev_scl && scl_bus && prev_sda && !sda_bus) begin n_start++; nbits = 0; end
        if (prev_scl && scl_bus && !prev_sda && sda_bus) n_stop++;
        if (!prev_scl && scl_bus) begin
            if (last_rise >= 0) begin
                p = cyc - last_rise;
                if (p < per_min) per_min = p;
                if (p > per_max) per_max = p;
            end
            last_rise = cyc;
            if (nbits < 8) cur = {cur[6:0], sda_bus};
            nbits++;
        end
        if (prev_scl && !scl_bus) begin
            if (nbits == 8) begin
                slv_lo = (nbyte < 8) ? !nack_mask[nbyte] : 1'b1;
            end else if (nbits == 9) begin
                slv_lo = 1'b0;
                if (nbyte < 8) rx[nbyte] = cur;
                nbyte++;
                nbits = 0;
            end
        end
        if (prev_rdy && !tx_ready_m) acc_t = cyc;
        if (tx_done_m) begin
            if (n_done < 8) begin done_t[n_done] = cyc + 1 - acc_t; done_abs[n_done] = cyc + 1; end
            n_done++;
        end
        if (ack_error_m) begin err_t = cyc + 1 - acc_t; n_err++; end
        if ((done_v & err_v) != 3'b000) both = 1'b1;
        prev_scl = scl_bus;
        prev_sda = sda_bus;
        prev_rdy = tx_ready_m;
    end

    task automatic clear_mon();
        @(posedge clk);
        n_done = 0; n_err = 0; err_t = -1; n_start = 0; n_stop = 0; nbits = 0; nbyte = 0;
        last_rise = -1; per_min = 1_000_000; per_max = 0; both = 1'b0; slv_lo = 1'b0; cur = 8'h00;
        for (int i = 0; i < 8; i++) begin done_t[i] = -1; done_abs[i] = -1; rx[i] = 8'hxx; end
        prev_scl = scl_bus; prev_sda = sda_bus; prev_rdy = tx_ready_m;
    endtask

    // Plays the control unit: presents the next byte after each latch, raises stop for the last.
    task automatic drive_txn(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input int nb, input int glitch_at, input bit no_wait,
                             output bit timed_out, output int rdy_t);
        logic [7:0] b [3];
        int k, guard;
        bit pend;
        b[0] = b0; b[1] = b1; b[2] = b2;
        if (!no_wait) @(negedge clk);
        tx_data = b[0]; stop = (nb == 1); en = 1'b1; start_req = 1'b1;
        @(negedge clk);
        start_req = 1'b0; tx_data = b[1];
        k = 0; pend = 1'b0; guard = 0; timed_out = 1'b0;
        while (!tx_ready_m && !timed_out) begin
            @(negedge clk);
            guard++;
            if (guard == glitch_at) start_req = 1'b1;
            else if (guard == glitch_at + 1) begin start_req = 1'b0; en = 1'b0; end
            if (pend) begin
                pend = 1'b0; k++;
                stop = (k == nb - 1);
                if (k + 1 < 3) tx_data = b[k + 1];
            end
            if (tx_done_m) pend = 1'b1;
            if (guard > 200 * QA) timed_out = 1'b1;
        end
        rdy_t = cyc - acc_t;
        stop = 1'b0;
    endtask

    task automatic test_reset();
        n_chk++; if (rdy_v !== 3'b111) begin n_fail++; $display("FAIL rst_ready: got %b expected 111", rdy_v); end
        n_chk++; if (done_v !== 3'b000) begin n_fail++; $display("FAIL rst_done: got %b expected 000", done_v); end
        n_chk++; if (err_v !== 3'b000) begin n_fail++; $display("FAIL rst_ackerr: got %b expected 000", err_v); end
        n_chk++; if ({scl_bus, sda_bus} !== 2'b11) begin n_fail++; $display("FAIL rst_bus: got %b expected 11", {scl_bus, sda_bus}); end
        @(negedge clk); reset = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++; if ({rdy_v, scl_bus, sda_bus} !== 5'b11111) begin n_fail++; $display("FAIL idle_after_rst: got %b expected 11111", {rdy_v, scl_bus, sda_bus}); end
    endtask

    task automatic test_basic();
        bit to; int rt;
        sel = 2'd0; nack_mask = 8'h00; clear_mon();
        drive_txn(8'h42, 8'h12, 8'h80, 3, -1, 1'b0, to, rt);
        n_chk++; if (to !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: got %0d expected 0", to); end
        n_chk++; if (n_done !== 3) begin n_fail++; $display("FAIL basic_done_cnt: got %0d expected 3", n_done); end
        n_chk++; if (done_t[0] !== 40 * QA) begin n_fail++; $display("FAIL basic_done0_t: got %0d expected %0d", done_t[0], 40 * QA); end
        n_chk++; if (done_t[1] !== 76 * QA) begin n_fail++; $display("FAIL basic_done1_t: got %0d expected %0d", done_t[1], 76 * QA); end
        n_chk++; if (done_t[2] !== 116 * QA) begin n_fail++; $display("FAIL basic_done2_t: got %0d expected %0d", done_t[2], 116 * QA); end
        n_chk++; if (rt !== 116 * QA) begin n_fail++; $display("FAIL basic_ready_t: got %0d expected %0d", rt, 116 * QA); end
        n_chk++; if ({rx[0], rx[1], rx[2]} !== 24'h42_12_80) begin n_fail++; $display("FAIL basic_bytes: got %h expected 421280", {rx[0], rx[1], rx[2]}); end
        n_chk++; if ({n_start, n_stop, n_err} !== {32'd1, 32'd1, 32'd0}) begin n_fail++; $display("FAIL basic_start_stop_err: got %0d %0d %0d expected 1 1 0", n_start, n_stop, n_err); end
        n_chk++; if (per_min !== 4 * QA || per_max !== 4 * QA) begin n_fail++; $display("FAIL basic_scl_period: got %0d..%0d expected %0d", per_min, per_max, 4 * QA); end
    endtask

    task automatic test_nack();
        bit to; int rt;
        sel = 2'd1; nack_mask = 8'b0000_0010; clear_mon();
        drive_txn(8'h21, 8'h43, 8'h65, 3, -1, 1'b0, to, rt);
        n_chk++; if (to !== 1'b0) begin n_fail++; $display("FAIL nack_timeout: got %0d expected 0", to); end
        n_chk++; if (n_done !== 1 || done_t[0] !== 40 * QB) begin n_fail++; $display("FAIL nack_done: got %0d at %0d expected 1 at %0d", n_done, done_t[0], 40 * QB); end
        n_chk++; if (n_err !== 1 || err_t !== 80 * QB) begin n_fail++; $display("FAIL nack_ackerr: got %0d at %0d expected 1 at %0d", n_err, err_t, 80 * QB); end
        n_chk++; if (n_stop !== 1 || rx[1] !== 8'h43) begin n_fail++; $display("FAIL nack_stop_byte: got %0d %h expected 1 43", n_stop, rx[1]); end
        n_chk++; if (tx_ready_m !== 1'b1) begin n_fail++; $display("FAIL nack_ready: got %b expected 1", tx_ready_m); end
    endtask

    task automatic test_no_check_ack();
        bit to; int rt;
        sel = 2'd2; nack_mask = 8'hFF; clear_mon();
        drive_txn(8'h0F, 8'hF0, 8'hAA, 3, -1, 1'b0, to, rt);
        n_chk++; if (n_done !== 3 || n_err !== 0) begin n_fail++; $display("FAIL nochk_counts: got done %0d err %0d expected 3 0", n_done, n_err); end
        n_chk++; if (done_t[2] !== 116 * QB) begin n_fail++; $display("FAIL nochk_done_t: got %0d expected %0d", done_t[2], 116 * QB); end
        n_chk++; if ({rx[0], rx[1], rx[2]} !== 24'h0F_F0_AA) begin n_fail++; $display("FAIL nochk_bytes: got %h expected 0ff0aa", {rx[0], rx[1], rx[2]}); end
    endtask

    task automatic test_ignored_start();
        bit to; int rt, bad;
        sel = 2'd1; nack_mask = 8'h00; clear_mon();
        @(negedge clk); en = 1'b0; start_req = 1'b1;
        @(negedge clk); start_req = 1'b0;
        bad = 0;
        repeat (8 * QB) begin
            @(negedge clk);
            if ({rdy_v, scl_bus, sda_bus} !== 5'b11111) bad++;
        end
        n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL ign_no_en: got %0d busy cycles expected 0", bad); end
        clear_mon();
        drive_txn(8'h5A, 8'hC3, 8'h00, 2, 10 * QB, 1'b0, to, rt);
        n_chk++; if (n_start !== 1 || n_done !== 2) begin n_fail++; $display("FAIL ign_midbyte: got starts %0d dones %0d expected 1 2", n_start, n_done); end
        n_chk++; if (done_t[1] !== 80 * QB) begin n_fail++; $display("FAIL ign_done_t: got %0d expected %0d", done_t[1], 80 * QB); end
        n_chk++; if ({rx[0], rx[1]} !== 16'h5A_C3) begin n_fail++; $display("FAIL ign_bytes: got %h expected 5ac3", {rx[0], rx[1]}); end
    endtask

    task automatic test_reset_mid();
        bit to; int rt, guard;
        sel = 2'd1; nack_mask = 8'h00; clear_mon();
        @(negedge clk); tx_data = 8'h00; stop = 1'b1; en = 1'b1; start_req = 1'b1;
        @(negedge clk); start_req = 1'b0;
        guard = 0;
        while (!(nbits == 4 && scl_bus == 1'b0) && guard < 100 * QB) begin @(negedge clk); guard++; end
        n_chk++; if ({scl_bus, sda_bus} !== 2'b00) begin n_fail++; $display("FAIL mid_bus_before: got %b expected 00", {scl_bus, sda_bus}); end
        #2 reset = 1'b0;
        #1;
        n_chk++; if ({scl_bus, sda_bus} !== 2'b11) begin n_fail++; $display("FAIL mid_bus_released: got %b expected 11", {scl_bus, sda_bus}); end
        n_chk++; if ({done_v, err_v, rdy_v} !== 9'b000_000_111) begin n_fail++; $display("FAIL mid_outputs: got %b expected 000000111", {done_v, err_v, rdy_v}); end
        @(negedge clk); reset = 1'b1; stop = 1'b0;
        repeat (2) @(negedge clk);
        clear_mon();
        drive_txn(8'h3C, 8'h00, 8'h00, 1, -1, 1'b0, to, rt);
        n_chk++; if (n_done !== 1 || done_t[0] !== 44 * QB) begin n_fail++; $display("FAIL mid_fresh_done: got %0d at %0d expected 1 at %0d", n_done, done_t[0], 44 * QB); end
        n_chk++; if (rx[0] !== 8'h3C) begin n_fail++; $display("FAIL mid_fresh_byte: got %h expected 3c", rx[0]); end
    endtask

    task automatic test_back_to_back();
        bit to1, to2; int rt;
        sel = 2'd1; nack_mask = 8'h00; clear_mon();
        drive_txn(8'h99, 8'h00, 8'h00, 1, -1, 1'b0, to1, rt);
        drive_txn(8'h66, 8'h00, 8'h00, 1, -1, 1'b1, to2, rt);
        n_chk++; if (n_done !== 2 || n_start !== 2 || n_stop !== 2) begin n_fail++; $display("FAIL b2b_counts: got %0d %0d %0d expected 2 2 2", n_done, n_start, n_stop); end
        n_chk++; if ({rx[0], rx[1]} !== 16'h99_66) begin n_fail++; $display("FAIL b2b_bytes: got %h expected 9966", {rx[0], rx[1]}); end
        n_chk++; if (done_abs[1] - done_abs[0] !== 44 * QB + 1) begin n_fail++; $display("FAIL b2b_gap: got %0d expected %0d", done_abs[1] - done_abs[0], 44 * QB + 1); end
        n_chk++; if (both !== 1'b0) begin n_fail++; $display("FAIL done_and_ackerr_overlap: got %b expected 0", both); end
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; start_req = 1'b0; stop = 1'b0; tx_data = 8'h00;
        sel = 2'd0; slv_lo = 1'b0; nack_mask = 8'h00;
        repeat (3) @(negedge clk);
        test_reset();
        test_basic();
        test_nack();
        test_no_check_ack();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
